// File: rtl/memory_refill_responder.sv
// memory_refill_responder
//   Single-port word memory that answers two kinds of request:
//   - a 4-word block refill, returned as beats 0..3 after a fixed latency;
//   - a word or byte write, committed one cycle after acceptance and
//     acknowledged with a one-cycle wr_ack pulse.
//
// Ports
//   clk, rst_n                  clock (rising edge), async active-low reset
//   req_valid/req_ready         request handshake (ready only when idle)
//   req_we, req_addr,
//   req_wdata, req_byte         request kind, byte address, write data, byte mode
//   resp_valid/resp_ready       refill beat handshake
//   resp_data, resp_beat,
//   resp_last                   beat word, beat index, final-beat flag
//   wr_ack                      write committed (one cycle)
//   busy                        a transaction is in progress
module memory_refill_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH_LOG2 = 12,
  parameter int LATENCY    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic                  req_byte,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic [1:0]            resp_beat,
  output logic                  resp_last,
  output logic                  wr_ack,
  output logic                  busy
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int LANES = DATA_WIDTH / 8;
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, BURST, WRITE} state_t;

  state_t                 state_reg, state_next;
  logic [CNT_W-1:0]       cnt_reg, cnt_next;
  logic [1:0]             beat_reg, beat_next;
  logic [DEPTH_LOG2-1:0]  idx_reg, idx_next;
  logic [1:0]             lane_reg, lane_next;
  logic                   byte_reg, byte_next;
  logic [DATA_WIDTH-1:0]  wdata_reg, wdata_next;
  logic                   wr_ack_reg, wr_ack_next;

  // Backing store; contents survive reset.
  logic [DATA_WIDTH-1:0]  mem [DEPTH];
  logic [DATA_WIDTH-1:0]  rd_data_reg;
  logic                   rd_en;
  logic [DEPTH_LOG2-1:0]  rd_idx;
  logic                   wr_en;
  logic [LANES-1:0]       wr_be;
  logic [DATA_WIDTH-1:0]  wr_word;

  // Address bits above the array size are deliberately ignored (wrap).
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr[ADDR_WIDTH-1:DEPTH_LOG2+2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      beat_reg   <= '0;
      idx_reg    <= '0;
      lane_reg   <= '0;
      byte_reg   <= 1'b0;
      wdata_reg  <= '0;
      wr_ack_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      beat_reg   <= beat_next;
      idx_reg    <= idx_next;
      lane_reg   <= lane_next;
      byte_reg   <= byte_next;
      wdata_reg  <= wdata_next;
      wr_ack_reg <= wr_ack_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    beat_next   = beat_reg;
    idx_next    = idx_reg;
    lane_next   = lane_reg;
    byte_next   = byte_reg;
    wdata_next  = wdata_reg;
    wr_ack_next = 1'b0;
    rd_en       = 1'b0;
    rd_idx      = {idx_reg[DEPTH_LOG2-1:2], beat_reg};
    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          idx_next   = req_addr[DEPTH_LOG2+1:2];
          lane_next  = req_addr[1:0];
          byte_next  = req_byte;
          wdata_next = req_wdata;
          if (req_we) begin
            state_next = WRITE;
          end else begin
            idx_next[1:0] = 2'b00;  // refills always start at the block base
            cnt_next      = CNT_LOAD;
            state_next    = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_reg == '0) begin
          // Fetch beat 0 so it is on resp_data as BURST is entered.
          state_next = BURST;
          beat_next  = 2'd0;
          rd_en      = 1'b1;
          rd_idx     = {idx_reg[DEPTH_LOG2-1:2], 2'b00};
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      BURST: begin
        if (resp_ready) begin
          if (beat_reg == 2'd3) begin
            state_next = IDLE;
            beat_next  = 2'd0;
          end else begin
            // Prefetch the following beat; the read register only changes
            // on a transfer, which keeps resp_data stable under backpressure.
            beat_next = beat_reg + 2'd1;
            rd_en     = 1'b1;
            rd_idx    = {idx_reg[DEPTH_LOG2-1:2], beat_reg + 2'd1};
          end
        end
      end
      WRITE: begin
        state_next  = IDLE;
        wr_ack_next = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  // Commit happens only while in WRITE; an async reset in WRITE drops the
  // state back to IDLE before the commit edge, so the array is untouched.
  assign wr_en   = (state_reg == WRITE);
  assign wr_word = byte_reg ? {LANES{wdata_reg[7:0]}} : wdata_reg;

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_be
      assign wr_be[gi] = !byte_reg || (lane_reg == 2'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < LANES; i++) begin
        if (wr_be[i]) mem[idx_reg][i*8 +: 8] <= wr_word[i*8 +: 8];
      end
    end
    if (rd_en) rd_data_reg <= mem[rd_idx];
  end

  assign req_ready  = (state_reg == IDLE);
  assign busy       = (state_reg != IDLE);
  assign resp_valid = (state_reg == BURST);
  assign resp_beat  = beat_reg;
  assign resp_last  = resp_valid && (beat_reg == 2'd3);
  assign resp_data  = resp_valid ? rd_data_reg : '0;
  assign wr_ack     = wr_ack_reg;

endmodule
